instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage between the PC register and decode.
- Issues one instruction-memory request per PC value and buffers returned instructions with their PC in a small queue.
- Presents queued instructions to decode with a valid/ready handshake.
- Drives wpcir back to the PC register so the PC advances exactly once per accepted instruction, or on a redirect.

Parameters:
- DEPTH, 2, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pc_in  in  32  current PC from the PC register.
- wpcir  out  1  PC write inhibit: 1 = hold PC, 0 = PC loads its next value.
- redirect  in  1  one-cycle pulse: branch/jump taken; next-PC logic already selects the target.
- imem_req  out  1  memory request; held until imem_ack.
- imem_addr  out  32  registered request address.
- imem_ack  in  1  response valid this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts head.
- id_inst  out  32  head instruction; 32'h0 when id_valid=0.
- id_pc  out  32  head PC.
- id_pc4  out  32  head PC + 4, modulo 2^32.

Behaviour:
- Reset (resetn=0, asynchronous) values:
  - state=IDLE, count=0.
  - imem_req=0, imem_addr=0.
  - id_valid=0, id_inst=0, id_pc=0, id_pc4=0.
  - wpcir=1.
- FSM states:
  - IDLE:
    - If redirect=0 and count<DEPTH: assert imem_req next cycle, latch imem_addr<=pc_in, go REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - imem_req=1; imem_addr is stable.
    - On imem_ack with redirect=0: enqueue {pc=imem_addr, inst=imem_rdata}.
    - If the post-enqueue count (with any same-cycle dequeue counted) is below DEPTH: stay in REQ, imem_addr<=pc_in+4.
    - Otherwise: drop imem_req, go IDLE.
    - On redirect without ack: go DRAIN, keep imem_req and imem_addr unchanged.
    - On redirect with ack: discard the response, go IDLE.
  - DRAIN:
    - imem_req held with the old imem_addr until imem_ack.
    - The response is discarded; then go IDLE.
    - A further redirect while in DRAIN only refreshes the flush.
- wpcir (combinational):
  - 0 in any cycle where an ack is enqueued, or where redirect=1.
  - 1 otherwise.
  - The PC therefore advances once per enqueued instruction; the next request uses the updated PC.
- Queue and handshake:
  - Dequeue when id_valid && id_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Full (count=DEPTH): no new request is issued; an in-flight ack always has a free slot, because issue requires space.
  - Empty: id_valid=0 and id_inst=0.
  - Head outputs are registered from the queue storage; there is no same-cycle memory-to-decode bypass.
- Redirect:
  - Flushes the queue (count<=0); id_valid=0 from the next cycle.
  - Any dequeue in the redirect cycle is ignored.
  - Redirect has priority over enqueue and over issue.
- Handshake and timing rules:
  - imem_req never drops before imem_ack.
  - Minimum fetch latency: 1 cycle from pc_in stable to imem_req.
  - Throughput: 1 instruction per cycle with a zero-wait memory and id_ready=1.
- Reset mid-transaction:
  - Everything returns to reset values immediately.
  - A pending memory response after reset is ignored in IDLE.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cycles[31:0] and perf_flushed[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - perf_stall_cycles increments each cycle with imem_req=1 and imem_ack=0.
  - perf_flushed increments by the number of valid queue entries discarded, plus 1 for each discarded in-flight response.
- When undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - Fetch state enum {IDLE, REQ, DRAIN}.
  - INST_W=32 and ADDR_W=32.
  - NOP_INST=32'h0.
  - Queue entry typedef {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of DEPTH entries with push, pop and flush.
  - Count output and full/empty flags.
  - Flush has priority over push and pop.

Test Plan:
- Reset then pc_in=0x0, zero-wait memory returning 0x20080005 at 0x0 and 0x20090007 at 0x4, id_ready=1:
  - id_valid rises.
  - id_pc=0x0 with id_inst=0x20080005, then id_pc=0x4 with id_inst=0x20090007; id_pc4 is 0x4, then 0x8.
  - wpcir pulses low once per ack.
- id_ready=0, DEPTH=2:
  - After two acks: count=2, imem_req=0, wpcir stays 1.
  - Raising id_ready drains the queue, then fetch resumes at pc 0x8.
- Memory with 3-cycle ack latency, redirect pulse in the second wait cycle:
  - FSM enters DRAIN; imem_addr is unchanged until ack.
  - The response is not enqueued; id_valid=0.
  - The next request uses the new pc_in=0x100.
- Redirect coincident with imem_ack and a full queue:
  - count=0 next cycle; the response is discarded.
  - wpcir=0 exactly that cycle.
- pc_in=0xFFFFFFFC fetched: id_pc4=0x00000000.
- resetn pulsed low while in REQ:
  - imem_req=0 and id_valid=0 immediately (asynchronous); wpcir=1.
  - A late imem_ack is ignored.
  - Under IFETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: small synchronous queue of fetched {pc, inst} entries.
// Flush empties the queue and wins over push and pop in the same cycle.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: issues one memory request per PC, queues returned
// instructions with their PC and hands them to decode over valid/ready.
// wpcir lets the PC register advance once per enqueued instruction or on redirect.
// Optional build macro IFETCH_PERF_CNT_EN adds stall / flush counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no request outstanding; issue when queue has room, no redirect
//   REQ   | request outstanding at imem_addr; ack enqueues and may chain
//   DRAIN | request outstanding but its response is stale; discard on ack
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              wpcir,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ack_enq;
    logic              deq;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     count;
    logic [CW:0]       post_count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // A redirect cancels any dequeue; the queue is flushed instead.
    assign deq        = id_valid && id_ready && !redirect;
    assign post_count = {1'b0, count} + (CW+1)'(1) - (CW+1)'(deq);
    assign push_entry = '{pc: addr_q, inst: imem_rdata};

    // State and request address registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; redirect outranks both enqueue and issue.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ack_enq = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && !fifo_full) begin
                    addr_d  = pc_in;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    ack_enq = 1'b1;
                    // pc_in still holds the acked PC; it advances this edge.
                    if (post_count < (CW+1)'(DEPTH)) begin
                        addr_d = pc_in + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (ack_enq),
        .push_data_i (push_entry),
        .pop_i       (deq),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign wpcir     = !(ack_enq || redirect);
    assign id_valid  = !fifo_empty;
    assign id_inst   = fifo_empty ? NOP_INST : head.inst;
    assign id_pc     = fifo_empty ? '0 : head.pc;
    assign id_pc4    = fifo_empty ? '0 : head.pc + 32'd4;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flushed_q, flushed_d;
    logic [31:0] flush_inc;
    logic [32:0] flush_sum;
    logic        discard;

    assign discard   = imem_ack && (((state_q == REQ) && redirect) || (state_q == DRAIN));
    assign flush_inc = (redirect ? 32'(count) : 32'd0) + (discard ? 32'd1 : 32'd0);
    assign flush_sum = {1'b0, flushed_q} + {1'b0, flush_inc};

    // Saturating next values for both counters.
    always_comb begin
        stall_d   = stall_q;
        flushed_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        if (imem_req && !imem_ack && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushed      = flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC register and memory models drive the DUT;
// a monitor keeps a queue of expected {pc, inst} entries in program order and
// checks every decode handshake and every wpcir value against it.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] pc_in;
    logic        wpcir;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushed;
`endif

    instruction_fetch #(.DEPTH(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pc_in      (pc_in),
        .wpcir      (wpcir),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushed      (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_pop = 0;
    int          n_wrap = 0;
    logic [31:0] redirect_target = 32'h0;
    bit          mem_auto = 1'b1;
    int          lat_mode = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0007;
            default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // PC register: loads next PC whenever wpcir is low.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) pc_in <= 32'h0;
        else if (!wpcir) pc_in <= redirect ? redirect_target : pc_in + 32'd4;
    end

    // Instruction memory: each request answered after lat_mode (or random) wait cycles.
    int lat_left = 0;
    bit in_req = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!mem_auto || !resetn) begin
            if (mem_auto) imem_ack = 1'b0;
            in_req = 1'b0;
        end else if (imem_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                lat_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (lat_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_fn(imem_addr);
                in_req     = 1'b0;
            end else begin
                imem_ack = 1'b0;
                lat_left--;
            end
        end else begin
            imem_ack = 1'b0;
            in_req   = 1'b0;
        end
    end

    // Reference model + scoreboard: program-order PCs, flushed on redirect,
    // responses to requests overtaken by a redirect are dropped.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t        sb[$];
    exp_t        m_e;
    logic [31:0] exp_pc = 32'h0;
    bit          poisoned = 1'b0;
    bit          m_enq;

    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            exp_pc   = 32'h0;
            poisoned = 1'b0;
        end else begin
            m_enq = imem_req && imem_ack && !redirect && !poisoned;
            chk("wpcir", {31'b0, wpcir}, {31'b0, !(m_enq || redirect)});
            chk("id_valid", {31'b0, id_valid}, {31'b0, sb.size() != 0});
            if (!id_valid) chk("id_inst_when_empty", id_inst, 32'h0);
            if (id_valid && id_ready && !redirect && sb.size() != 0) begin
                m_e = sb.pop_front();
                chk("id_pc", id_pc, m_e.pc);
                chk("id_inst", id_inst, m_e.inst);
                chk("id_pc4", id_pc4, m_e.pc + 32'd4);
                n_pop++;
                if (m_e.pc == 32'hFFFF_FFFC) n_wrap++;
            end
            if (redirect) begin
                sb.delete();
                exp_pc = redirect_target;
            end else if (m_enq) begin
                sb.push_back('{pc: exp_pc, inst: mem_fn(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req && imem_ack) poisoned = 1'b0;
            else if (imem_req && redirect) poisoned = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30 && !imem_req; i++) cyc();
        chk("wait_req_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 30 && !imem_ack; i++) cyc();
        chk("wait_ack_timeout", {31'b0, imem_ack}, 32'd1);
    endtask

    initial begin
        // Reset values.
        #1 resetn = 1'b0;
        #2;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_wpcir", {31'b0, wpcir}, 32'd1);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_perf_stall", perf_stall_cycles, 32'h0);
        chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif

        // Zero-wait memory, decode always ready: stream from 0x0.
        lat_mode = 0;
        id_ready = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b1;
        repeat (8) cyc();
        chk("stream_popped", {31'b0, n_pop >= 4}, 32'd1);

        // Decode stalled: queue fills with two entries, fetch stops.
        id_ready = 1'b0;
        do_reset();
        repeat (6) cyc();
        chk("full_imem_req", {31'b0, imem_req}, 32'd0);
        chk("full_wpcir", {31'b0, wpcir}, 32'd1);
        chk("full_id_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        cyc();
        wait_req();
        chk("resume_addr", imem_addr, 32'h8);

        // 3-cycle memory, redirect in second wait cycle.
        lat_mode = 3;
        do_reset();
        wait_req();
        cyc();
        redirect_target = 32'h100;
        redirect = 1'b1;
        cyc();
        redirect = 1'b0;
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h0);
        wait_ack();
        chk("drain_ack_addr", imem_addr, 32'h0);
        cyc();
        chk("drain_done_req", {31'b0, imem_req}, 32'd0);
        chk("drain_id_valid", {31'b0, id_valid}, 32'd0);
        cyc();
        chk("redirect_addr", imem_addr, 32'h100);

        // Redirect together with the ack that would fill the queue.
        lat_mode = 2;
        id_ready = 1'b0;
        do_reset();
        wait_ack();
        cyc();
        wait_ack();
        redirect_target = 32'h200;
        redirect = 1'b1;
        #1;
        chk("redir_ack_wpcir", {31'b0, wpcir}, 32'd0);
        cyc();
        redirect = 1'b0;
        chk("redir_ack_flushed", {31'b0, id_valid}, 32'd0);
        id_ready = 1'b1;
        repeat (10) cyc();

        // Fetch across the top of the address space.
        lat_mode = 0;
        redirect_target = 32'hFFFF_FFFC;
        redirect = 1'b1;
        cyc();
        redirect = 1'b0;
        repeat (12) cyc();
        chk("wrap_seen", {31'b0, n_wrap > 0}, 32'd1);

        // Asynchronous reset while a request is outstanding; late ack ignored.
        mem_auto = 1'b0;
        imem_ack = 1'b0;
        cyc();
        wait_req();
        resetn = 1'b0;
        #1;
        chk("arst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("arst_wpcir", {31'b0, wpcir}, 32'd1);
        chk("arst_imem_addr", imem_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("arst_perf_stall", perf_stall_cycles, 32'h0);
        chk("arst_perf_flushed", perf_flushed, 32'h0);
`endif
        cyc();
        resetn     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        chk("late_ack_id_valid", {31'b0, id_valid}, 32'd0);
        cyc();
        chk("late_ack_id_valid2", {31'b0, id_valid}, 32'd0);
        mem_auto = 1'b1;

        // Randomized traffic: latency, decode backpressure and redirects.
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 29) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                          : ($urandom & 32'hFFFF_FFFC);
        end
        cyc();
        redirect = 1'b0;
        id_ready = 1'b1;
        repeat (20) cyc();
        chk("random_popped", {31'b0, n_pop > 500}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
